// File: rtl/activation_cache.sv
// Dilated tap history: a circular buffer of 3*DILATION+1 sample vectors that
// presents four equally spaced taps one cycle after every write once primed.
module activation_cache #(
   parameter int W        = 16,
   parameter int D        = 8,
   parameter int DILATION = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           inp_v,
   input  logic [D*W-1:0] packed_inp,
   output logic [D*W-1:0] packed_a0,
   output logic [D*W-1:0] packed_a1,
   output logic [D*W-1:0] packed_a2,
   output logic [D*W-1:0] packed_a3,
   output logic           out_v,
   output logic           primed
);

   localparam int DEPTH = 3 * DILATION + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int FW    = $clog2(DEPTH + 1);

   typedef enum logic {FILLING, STREAMING} state_t;
   typedef logic [D*W-1:0] vec_t;

   vec_t          mem_q [DEPTH];
   vec_t          tap_q [4];
   vec_t          tap_d [4];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FW-1:0] fill_q, fill_d;
   state_t        state_q, state_d;
   logic          out_v_q, out_v_d;
   logic          emit;

   // Buffer slot holding the sample k*DILATION writes older than 'newest'.
   function automatic logic [PW-1:0] tap_idx(input logic [PW-1:0] newest, input int k);
      int s;
      s = int'(newest) + DEPTH - k * DILATION;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   assign emit = (state_q == STREAMING) || (fill_q == FW'(DEPTH - 1));

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      out_v_d  = 1'b0;
      for (int k = 0; k < 4; k++) tap_d[k] = tap_q[k];

      if (flush) begin
         state_d  = FILLING;
         wr_ptr_d = '0;
         fill_d   = '0;
      end else if (inp_v) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (fill_q != FW'(DEPTH)) fill_d = fill_q + 1'b1;
         if (emit) begin
            state_d = STREAMING;
            out_v_d = 1'b1;
            // Newest tap bypasses the buffer; older slots are untouched by this write.
            for (int k = 1; k < 4; k++) tap_d[3-k] = mem_q[tap_idx(wr_ptr_q, k)];
            tap_d[3] = packed_inp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILLING;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         out_v_q  <= 1'b0;
         for (int k = 0; k < 4; k++) tap_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         out_v_q  <= out_v_d;
         for (int k = 0; k < 4; k++) tap_q[k] <= tap_d[k];
      end
   end

   // NOTE: the sample memory is deliberately not reset; the fill counter guards every read.
   always_ff @(posedge clk) begin
      if (!rst && !flush && inp_v) mem_q[wr_ptr_q] <= packed_inp;
   end

   assign packed_a0 = tap_q[0];
   assign packed_a1 = tap_q[1];
   assign packed_a2 = tap_q[2];
   assign packed_a3 = tap_q[3];
   assign out_v     = out_v_q;
   assign primed    = (state_q == STREAMING);

endmodule

// File: tb/tb_activation_cache.sv
// Bench: two caches (DILATION=2 and 1) checked every cycle against a sample-log model.
module tb_activation_cache;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int VW = W * D;
   typedef logic [VW-1:0] vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s   [2];
   logic flush_s [2];
   logic inp_v_s [2];
   vec_t inp_s   [2];
   vec_t a0_s    [2];
   vec_t a1_s    [2];
   vec_t a2_s    [2];
   vec_t a3_s    [2];
   logic out_v_s [2];
   logic primed_s[2];

   activation_cache #(.W(W), .D(D), .DILATION(2)) dut2 (
      .clk(clk), .rst(rst_s[0]), .flush(flush_s[0]), .inp_v(inp_v_s[0]),
      .packed_inp(inp_s[0]), .packed_a0(a0_s[0]), .packed_a1(a1_s[0]),
      .packed_a2(a2_s[0]), .packed_a3(a3_s[0]), .out_v(out_v_s[0]), .primed(primed_s[0]));

   activation_cache #(.W(W), .D(D), .DILATION(1)) dut1 (
      .clk(clk), .rst(rst_s[1]), .flush(flush_s[1]), .inp_v(inp_v_s[1]),
      .packed_inp(inp_s[1]), .packed_a0(a0_s[1]), .packed_a1(a1_s[1]),
      .packed_a2(a2_s[1]), .packed_a3(a3_s[1]), .out_v(out_v_s[1]), .primed(primed_s[1]));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input vec_t act, input vec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int n);
      logic [W-1:0] e;
      e = W'(n);
      return {D{e}};
   endfunction

   // Model: log of samples accepted since the last reset/flush; taps index straight into it.
   int   dil_c [2] = '{2, 1};
   vec_t hist  [2][256];
   int   h_n   [2] = '{0, 0};
   logic m_out [2] = '{1'b0, 1'b0};
   logic m_prim[2] = '{1'b0, 1'b0};
   vec_t m_tap [2][4];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_out[i] = 1'b0;
         if (rst_s[i]) begin
            h_n[i] = 0;
            for (int j = 0; j < 4; j++) m_tap[i][j] = '0;
         end else if (flush_s[i]) begin
            h_n[i] = 0;
         end else if (inp_v_s[i] && h_n[i] < 256) begin
            hist[i][h_n[i]] = inp_s[i];
            h_n[i]++;
            if (h_n[i] >= 3 * dil_c[i] + 1) begin
               m_out[i] = 1'b1;
               for (int j = 0; j < 4; j++) m_tap[i][j] = hist[i][h_n[i] - 1 - (3 - j) * dil_c[i]];
            end
         end
         m_prim[i] = (h_n[i] >= 3 * dil_c[i] + 1);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("out_v[%0d]", i), VW'(out_v_s[i]), VW'(m_out[i]));
         check($sformatf("primed[%0d]", i), VW'(primed_s[i]), VW'(m_prim[i]));
         check($sformatf("a0[%0d]", i), a0_s[i], m_tap[i][0]);
         check($sformatf("a1[%0d]", i), a1_s[i], m_tap[i][1]);
         check($sformatf("a2[%0d]", i), a2_s[i], m_tap[i][2]);
         check($sformatf("a3[%0d]", i), a3_s[i], m_tap[i][3]);
      end
   end

   // Drive one cycle on instance i, then return at the next falling edge.
   task automatic drive(input int i, input logic r, input logic f, input logic v, input int n);
      rst_s[i]   = r;
      flush_s[i] = f;
      inp_v_s[i] = v;
      inp_s[i]   = mk(n);
      @(negedge clk);
      rst_s[i]   = 1'b0;
      flush_s[i] = 1'b0;
      inp_v_s[i] = 1'b0;
   endtask

   task automatic taps_are(input string name, input int i, input int t0, input int t1,
                           input int t2, input int t3);
      check({name, ".out_v"}, VW'(out_v_s[i]), VW'(1));
      check({name, ".a0"}, a0_s[i], mk(t0));
      check({name, ".a1"}, a1_s[i], mk(t1));
      check({name, ".a2"}, a2_s[i], mk(t2));
      check({name, ".a3"}, a3_s[i], mk(t3));
   endtask

   int pulses;

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_s[i] = 1'b1; flush_s[i] = 1'b0; inp_v_s[i] = 1'b0; inp_s[i] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      check("reset.out_v", VW'(out_v_s[0]), VW'(0));
      check("reset.primed", VW'(primed_s[0]), VW'(0));
      check("reset.a0", a0_s[0], '0);
      check("reset.a3", a3_s[1], '0);

      // Priming with DILATION=2
      for (int n = 0; n <= 5; n++) drive(0, 0, 0, 1, n);
      check("fill.out_v", VW'(out_v_s[0]), VW'(0));
      check("fill.primed", VW'(primed_s[0]), VW'(0));
      drive(0, 0, 0, 1, 6);
      taps_are("prime", 0, 0, 2, 4, 6);
      check("prime.primed", VW'(primed_s[0]), VW'(1));

      // Back-to-back streaming through pointer wrap
      pulses = 0;
      for (int n = 7; n <= 19; n++) begin
         drive(0, 0, 0, 1, n);
         if (out_v_s[0]) pulses++;
         if (n == 7) taps_are("n7", 0, 1, 3, 5, 7);
      end
      check("stream.pulses", VW'(pulses), VW'(13));
      taps_are("n19", 0, 13, 15, 17, 19);
      drive(0, 0, 0, 0, 0);
      check("idle.out_v", VW'(out_v_s[0]), VW'(0));
      check("idle.a3", a3_s[0], mk(19));

      // Negative sample as newest
      drive(0, 0, 0, 1, -1);
      check("neg.a3", a3_s[0], {D{16'hFFFF}});
      check("neg.a2", a2_s[0], mk(18));

      // Flush together with a write drops the sample
      drive(0, 0, 1, 1, 100);
      check("flush.primed", VW'(primed_s[0]), VW'(0));
      check("flush.out_v", VW'(out_v_s[0]), VW'(0));
      for (int n = 200; n <= 205; n++) drive(0, 0, 0, 1, n);
      check("refill.out_v", VW'(out_v_s[0]), VW'(0));
      drive(0, 0, 0, 1, 206);
      taps_are("refill", 0, 200, 202, 204, 206);
      // Flush in the cycle after a write: the write's pulse is already out
      drive(0, 0, 0, 1, 207);
      drive(0, 0, 1, 0, 0);
      check("flush2.out_v", VW'(out_v_s[0]), VW'(0));
      check("flush2.hold", a3_s[0], mk(207));

      // Reset mid-fill, with a sample presented during reset
      for (int n = 0; n <= 4; n++) drive(0, 0, 0, 1, n);
      drive(0, 1, 0, 1, 99);
      check("rst.a3", a3_s[0], '0);
      check("rst.primed", VW'(primed_s[0]), VW'(0));
      for (int n = 50; n <= 55; n++) drive(0, 0, 0, 1, n);
      check("rst.fill", VW'(out_v_s[0]), VW'(0));
      drive(0, 0, 0, 1, 56);
      taps_are("rst.first", 0, 50, 52, 54, 56);

      // DILATION=1, a write every third cycle
      pulses = 0;
      for (int n = 0; n <= 5; n++) begin
         drive(1, 0, 0, 1, n);
         if (out_v_s[1]) pulses++;
         if (n == 3) taps_are("d1.n3", 1, 0, 1, 2, 3);
         drive(1, 0, 0, 0, 0);
         drive(1, 0, 0, 0, 0);
      end
      check("d1.pulses", VW'(pulses), VW'(3));
      check("d1.a0", a0_s[1], mk(2));
      check("d1.a3", a3_s[1], mk(5));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/activation_cache.md
ACTIVATION_CACHE -- requirements
Module: activation_cache

Interface
REQ-001 Parameter W, default 16: bit width of each element.
REQ-002 Parameter D, default 8: elements per packed vector.
REQ-003 Parameter DILATION, default 1: sample spacing between taps; legal range 1..8.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as below.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 flush  input  1  discards the stored history without resetting the block.
REQ-008 inp_v  input  1  single-cycle strobe: packed_inp holds a new sample.
REQ-009 packed_inp  input  D*W  new signed sample vector; element 0 in the MSBs.
REQ-010 packed_a0  output  D*W  tap x[t-3*DILATION] (oldest).
REQ-011 packed_a1  output  D*W  tap x[t-2*DILATION].
REQ-012 packed_a2  output  D*W  tap x[t-DILATION].
REQ-013 packed_a3  output  D*W  tap x[t] (newest).
REQ-014 out_v  output  1  one-cycle pulse: the taps were updated this cycle.
REQ-015 primed  output  1  high while the history holds at least DEPTH samples.

Function
REQ-016 DEPTH SHALL equal 3*DILATION+1; storage SHALL be a circular buffer of DEPTH entries of D*W bits.
REQ-017 The block SHALL hold a write pointer (0..DEPTH-1) and a fill counter (0..DEPTH) that saturates at DEPTH.
REQ-018 On a cycle with inp_v=1 and flush=0:
- the block SHALL write packed_inp at the write pointer;
- the write pointer SHALL increment and wrap from DEPTH-1 to 0;
- the fill counter SHALL increment unless it is already at DEPTH.
REQ-019 States: FILLING (fill < DEPTH) and STREAMING (fill = DEPTH); primed SHALL be 1 exactly in STREAMING.
REQ-020 The transition FILLING to STREAMING SHALL occur on the accepted write that makes fill = DEPTH.
REQ-021 In STREAMING, the cycle after an accepted write SHALL assert out_v=1 for exactly one cycle, with the taps loaded from buffer entries (newest - k*DILATION) mod DEPTH for k=3,2,1,0, mapped to a0..a3. Latency from inp_v to out_v is 1 cycle.
REQ-022 The write that completes filling SHALL itself produce an out_v pulse on the next cycle.
REQ-023 In FILLING, out_v SHALL stay 0 and the taps SHALL hold their previous values.
REQ-024 The taps SHALL remain stable between out_v pulses.
REQ-025 inp_v asserted on every cycle SHALL be supported, giving one out_v per cycle after priming, with no samples lost.
REQ-026 Tap values SHALL be bit-exact copies of the stored samples, with no arithmetic, sign change or truncation.
REQ-027 flush=1 SHALL, on the next edge, set the fill counter and write pointer to 0, primed to 0 and out_v to 0. Buffer and tap contents are not cleared.
REQ-028 flush=1 together with inp_v=1 SHALL drop the sample, so flush has priority.
REQ-029 flush=1 in the cycle after a write SHALL still let the pending out_v pulse from that write emit.
REQ-030 Inputs SHALL be sampled only on the rising edge of clk; no combinational path from any input to any output.

Reset
REQ-031 rst=1 SHALL, on the next edge, set out_v=0, primed=0, fill counter=0, write pointer=0 and packed_a0..a3 = 0, with buffer contents left unspecified.
REQ-032 rst SHALL have priority over flush and inp_v; a sample presented during rst SHALL be dropped.
REQ-033 rst asserted mid-fill or mid-stream SHALL require a full DEPTH new samples before the next out_v.

Verification (W=16, D=8; sample n has all elements = n)
REQ-034 DILATION=2, feed n=0..6 one per cycle -> no out_v for n=0..5; the cycle after n=6: out_v=1, primed=1, a0=0, a1=2, a2=4, a3=6.
REQ-035 DILATION=2, continue n=7..19 back-to-back -> 13 consecutive out_v pulses; after n=7, taps = 1,3,5,7; after n=19, taps = 13,15,17,19 (pointer wrap checked).
REQ-036 DILATION=1, inp_v every 3rd cycle, n=0..5 -> pulses only after n=3,4,5; final taps = 2,3,4,5; taps stable between pulses.
REQ-037 DILATION=2, primed, flush together with inp_v carrying n=100 -> primed=0 next cycle, no out_v; then feed n=200..206 -> out_v after 206 with taps 200,202,204,206 (100 never appears).
REQ-038 DILATION=2, rst after n=0..4, then feed n=50..56 -> outputs 0 right after rst; first out_v only after 56, taps 50,52,54,56.
REQ-039 Negative data: n=-1 (16'hFFFF) as the newest sample -> a3 = 16'hFFFF in every element, with no sign corruption.
